// File: rtl/switch_debouncer_if.sv
// Signal bundle between the raw switch pins, the debouncer and the user-facing logic.
// The master side is the debouncer; the slave side drives pins and consumes the clean outputs.
interface switch_debouncer_if #(
    parameter int NUM_SW = 3
);
    logic [NUM_SW-1:0] i_sw;
    logic [NUM_SW-1:0] o_sw_state;
    logic [NUM_SW-1:0] o_sw_rise;
    logic [NUM_SW-1:0] o_sw_fall;
    logic [NUM_SW-1:0] o_sw_toggle;
    logic              o_any_event;

    modport master (
        input  i_sw,
        output o_sw_state,
        output o_sw_rise,
        output o_sw_fall,
        output o_sw_toggle,
        output o_any_event
    );

    modport slave (
        output i_sw,
        input  o_sw_state,
        input  o_sw_rise,
        input  o_sw_fall,
        input  o_sw_toggle,
        input  o_any_event
    );
endinterface

// File: rtl/switch_debouncer.sv
// Multi-channel switch conditioner: 2-FF synchronizer, hold-time debounce FSM,
// registered rise/fall pulses and a per-channel toggle latch.
module switch_debouncer #(
    parameter int NUM_SW         = 3,
    parameter int DEBOUNCE_COUNT = 250000,
    parameter int CNT_W          = 18
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    switch_debouncer_if.master   sw_if
);
    typedef enum logic {ST_IDLE, ST_PENDING} dbn_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam bit               SINGLE_CYCLE = (DEBOUNCE_COUNT == 1);

    logic [NUM_SW-1:0] sync1_reg;
    logic [NUM_SW-1:0] sync2_reg;
    logic [NUM_SW-1:0] level_vec;
    logic [NUM_SW-1:0] rise_reg;
    logic [NUM_SW-1:0] fall_reg;
    logic [NUM_SW-1:0] toggle_reg;
    logic [NUM_SW-1:0] rise_next;
    logic [NUM_SW-1:0] fall_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            rise_reg   <= '0;
            fall_reg   <= '0;
            toggle_reg <= '0;
        end else begin
            sync1_reg  <= sw_if.i_sw;
            sync2_reg  <= sync1_reg;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            // Toggle follows the registered rise pulse, so it flips one edge later.
            toggle_reg <= toggle_reg ^ rise_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_chan
            dbn_state_t       fsm_reg, fsm_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             level_reg, level_next;
            logic             rise_ch, fall_ch;
            logic             differs;

            assign differs = (sync2_reg[gi] != level_reg);

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    fsm_reg   <= ST_IDLE;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else begin
                    fsm_reg   <= fsm_next;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                end
            end

            always_comb begin
                fsm_next   = fsm_reg;
                cnt_next   = cnt_reg;
                level_next = level_reg;
                rise_ch    = 1'b0;
                fall_ch    = 1'b0;
                case (fsm_reg)
                    ST_IDLE: begin
                        cnt_next = '0;
                        if (differs) begin
                            if (SINGLE_CYCLE) begin
                                level_next = sync2_reg[gi];
                                rise_ch    = sync2_reg[gi];
                                fall_ch    = ~sync2_reg[gi];
                            end else begin
                                fsm_next = ST_PENDING;
                                cnt_next = CNT_ONE;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (!differs) begin
                            // Input bounced back before the hold time: drop the candidate.
                            fsm_next = ST_IDLE;
                            cnt_next = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            fsm_next   = ST_IDLE;
                            cnt_next   = '0;
                            level_next = sync2_reg[gi];
                            rise_ch    = sync2_reg[gi];
                            fall_ch    = ~sync2_reg[gi];
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        fsm_next = ST_IDLE;
                        cnt_next = '0;
                    end
                endcase
            end

            assign level_vec[gi] = level_reg;
            assign rise_next[gi] = rise_ch;
            assign fall_next[gi] = fall_ch;
        end
    endgenerate

    assign sw_if.o_sw_state  = level_vec;
    assign sw_if.o_sw_rise   = rise_reg;
    assign sw_if.o_sw_fall   = fall_reg;
    assign sw_if.o_sw_toggle = toggle_reg;
    assign sw_if.o_any_event = |{rise_reg, fall_reg};
endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios followed by random
// switch activity, all checked cycle by cycle against a run-length reference model.
module tb_switch_debouncer;
    localparam int NSW = 3;
    localparam int DC  = 4;
    localparam int CW  = 3;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    logic chk_en  = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    switch_debouncer_if #(.NUM_SW(NSW)) sw_if ();

    switch_debouncer #(
        .NUM_SW(NSW), .DEBOUNCE_COUNT(DC), .CNT_W(CW)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .sw_if  (sw_if)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a pin value reaches the debouncer two edges after sampling, and is
    // accepted once it has disagreed with the accepted level for DC consecutive edges.
    logic [NSW-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_rise = '0, m_fall = '0, m_tog = '0;
    int             m_run [NSW];

    always @(posedge i_clock) begin
        if (i_reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0;
            for (int c = 0; c < NSW; c++) m_run[c] = 0;
        end else begin
            m_tog  = m_tog ^ m_rise;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NSW; c++) begin
                if (m_s2[c] != m_level[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DC) begin
                        m_level[c] = m_s2[c];
                        m_rise[c]  = m_s2[c];
                        m_fall[c]  = ~m_s2[c];
                        m_run[c]   = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = sw_if.i_sw;
        end
    end

    always @(negedge i_clock) begin
        if (chk_en) begin
            chk("cycle",
                {19'd0, sw_if.o_sw_state, sw_if.o_sw_rise, sw_if.o_sw_fall, sw_if.o_sw_toggle, sw_if.o_any_event},
                {19'd0, m_level, m_rise, m_fall, m_tog, |{m_rise, m_fall}});
        end
    end

    task automatic do_reset(input logic [NSW-1:0] v);
        @(negedge i_clock);
        i_reset = 1'b1;
        sw_if.i_sw = v;
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    int n_rise, n_fall, n_evt;

    initial begin
        sw_if.i_sw = '0;

        // 1: reset with all switches high, then 6-edge acceptance.
        do_reset(3'b111);
        chk_en = 1'b1;
        chk("reset_outs", {sw_if.o_sw_state, sw_if.o_sw_rise, sw_if.o_sw_fall, sw_if.o_sw_toggle,
                           sw_if.o_any_event}, 13'd0);
        for (int e = 1; e <= 7; e++) begin
            @(negedge i_clock);
            if (e == 5) chk("t1_state_e5", sw_if.o_sw_state, 3'b000);
            if (e == 6) begin
                chk("t1_state_e6", sw_if.o_sw_state, 3'b111);
                chk("t1_rise_e6", sw_if.o_sw_rise, 3'b111);
            end
            if (e == 7) chk("t1_rise_e7", sw_if.o_sw_rise, 3'b000);
        end

        // 2: clean 0->1 on ch0 from a fresh reset.
        do_reset(3'b000);
        hold(3);
        sw_if.i_sw = 3'b001;
        for (int e = 0; e <= 6; e++) begin
            @(negedge i_clock);
            if (e == 4) chk("t2_state_k4", sw_if.o_sw_state[0], 1'b0);
            if (e == 5) begin
                chk("t2_state_k5", sw_if.o_sw_state[0], 1'b1);
                chk("t2_rise_k5", sw_if.o_sw_rise[0], 1'b1);
                chk("t2_tog_k5", sw_if.o_sw_toggle[0], 1'b0);
            end
            if (e == 6) begin
                chk("t2_rise_k6", sw_if.o_sw_rise[0], 1'b0);
                chk("t2_tog_k6", sw_if.o_sw_toggle[0], 1'b1);
            end
        end

        // 4: ch0 rises while ch2 falls on the same edge.
        sw_if.i_sw = 3'b100;
        hold(10);
        sw_if.i_sw = 3'b001;
        n_evt = 0;
        for (int e = 0; e < 10; e++) begin
            @(negedge i_clock);
            if (sw_if.o_any_event) begin
                n_evt++;
                chk("t4_rise", sw_if.o_sw_rise, 3'b001);
                chk("t4_fall", sw_if.o_sw_fall, 3'b100);
            end
        end
        chk("t4_events", n_evt, 1);

        // 3: ch1 high for 3 cycles only.
        sw_if.i_sw = 3'b011;
        hold(3);
        sw_if.i_sw = 3'b001;
        n_evt = 0;
        for (int e = 0; e < 10; e++) begin
            @(negedge i_clock);
            if (sw_if.o_any_event) n_evt++;
        end
        chk("t3_events", n_evt, 0);
        chk("t3_state1", sw_if.o_sw_state[1], 1'b0);

        // 5: reset while ch0's count is in progress.
        do_reset(3'b000);
        hold(2);
        sw_if.i_sw = 3'b001;
        hold(4);
        i_reset = 1'b1;
        hold(1);
        i_reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(negedge i_clock);
            if (e == 5) chk("t5_state_e5", sw_if.o_sw_state[0], 1'b0);
            if (e == 6) chk("t5_state_e6", sw_if.o_sw_state[0], 1'b1);
        end

        // 6: two presses on ch2, each held 10 cycles.
        do_reset(3'b000);
        hold(3);
        n_rise = 0;
        n_fall = 0;
        for (int p = 0; p < 4; p++) begin
            sw_if.i_sw = (p % 2 == 0) ? 3'b100 : 3'b000;
            for (int e = 0; e < 10; e++) begin
                @(negedge i_clock);
                if (sw_if.o_sw_rise[2]) n_rise++;
                if (sw_if.o_sw_fall[2]) n_fall++;
                if (p == 1 && e == 0) chk("t6_tog_after1", sw_if.o_sw_toggle[2], 1'b1);
            end
        end
        chk("t6_rises", n_rise, 2);
        chk("t6_falls", n_fall, 2);
        chk("t6_tog_end", sw_if.o_sw_toggle[2], 1'b0);

        // Random activity with glitches and occasional resets; per-cycle model check covers it.
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clock);
            i_reset = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < NSW; c++) begin
                if ($urandom_range(0, 5) == 0) sw_if.i_sw[c] = ~sw_if.i_sw[c];
            end
        end
        i_reset = 1'b0;
        hold(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
